// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between the system-side byte source, the feeder,
// and the UART TX core. The feeder is the slave; the bench or system
// logic driving writes and reporting TX core busy is the master.
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);

  logic                  WR_EN;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  TX_EN;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_DATA_VALID;
  logic                  FULL;
  logic                  EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  WR_ERR;

  modport master (
    output WR_EN, WR_DATA, TX_EN, TX_BUSY,
    input  TX_P_DATA, TX_DATA_VALID, FULL, EMPTY, COUNT, WR_ERR
  );

  modport slave (
    input  WR_EN, WR_DATA, TX_EN, TX_BUSY,
    output TX_P_DATA, TX_DATA_VALID, FULL, EMPTY, COUNT, WR_ERR
  );

endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller in front of the UART TX core.
// Bytes are queued from the system side and handed to the TX core one
// at a time with a single-cycle valid pulse; the next byte goes out only
// after the core's busy flag has been seen high and then low again.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_feeder_if.slave   link
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   count_next;

  // Decide this cycle's push/pop and the resulting occupancy.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    push       = 1'b0;
    pop        = 1'b0;
    count_next = link.COUNT;
    // FULL is the registered flag, so a same-cycle pop never makes room.
    push = link.WR_EN && !link.FULL;
    pop  = (state == IDLE) && link.TX_EN && !link.EMPTY && !link.TX_BUSY;
    case ({push, pop})
      2'b10:   count_next = link.COUNT + COUNT_ONE;
      2'b01:   count_next = link.COUNT - COUNT_ONE;
      default: count_next = link.COUNT;
    endcase
  end

  // Store accepted bytes; storage needs no reset since COUNT gates every read.
  // NOTE: the memory array is deliberately left out of reset; only pointers and flags are cleared.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= link.WR_DATA;
    end
  end

  // Pointers, occupancy flags, error pulse and the launch state machine.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      link.COUNT         <= '0;
      link.EMPTY         <= 1'b1;
      link.FULL          <= 1'b0;
      link.WR_ERR        <= 1'b0;
      link.TX_DATA_VALID <= 1'b0;
      link.TX_P_DATA     <= '0;
    end else begin
      // Occupancy is tracked by COUNT so a full FIFO is never mistaken
      // for an empty one when the pointers meet after wrapping.
      link.COUNT  <= count_next;
      link.FULL   <= (count_next == COUNT_FULL);
      link.EMPTY  <= (count_next == '0);
      link.WR_ERR <= link.WR_EN && link.FULL;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      case (state)
        IDLE: begin
          link.TX_DATA_VALID <= 1'b0;
          if (pop) begin
            link.TX_P_DATA     <= mem[rd_ptr];
            link.TX_DATA_VALID <= 1'b1;
            rd_ptr             <= rd_ptr + PTR_ONE;
            state              <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Valid was set on the launch edge; clearing here makes it one cycle wide.
          link.TX_DATA_VALID <= 1'b0;
          if (link.TX_BUSY) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          link.TX_DATA_VALID <= 1'b0;
          if (!link.TX_BUSY) begin
            state <= IDLE;
          end
        end
        default: begin
          link.TX_DATA_VALID <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule
